// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap sequencer for the 3-stage RV32I pipeline.
// Handles CSRRW/RS/RC (and immediate forms), interrupt entry and mret return.
module csr_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_reg_rd,
  input  logic        csr_reg_wr,
  input  logic        is_mret,
  input  logic [2:0]  func3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  input  logic [31:0] pc_in,
  input  logic        instr_valid,
  input  logic        timer_irq,
  input  logic        ext_irq,
  output logic [31:0] rdata,
  output logic        epc_taken,
  output logic [31:0] epc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

  logic        timer_s1, timer_s2, ext_s1, ext_s2;
  logic        mstatus_mie, mstatus_mpie;
  logic        mie_mtie, mie_meie;
  logic [31:0] mtvec, mepc, mcause;
  logic [63:0] mcycle;

  logic [31:0] mstatus_val, mie_val, mip_val;
  logic [31:0] old_val, src, new_val;
  logic        op_ok, wr_en;
  logic        irq_pending, trap_go, mret_go, ext_sel;
  logic [4:0]  cause_code;

  assign mstatus_val = {24'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign mie_val     = {20'b0, mie_meie, 3'b0, mie_mtie, 7'b0};
  assign mip_val     = {20'b0, ext_s2, 3'b0, timer_s2, 7'b0};

  assign op_ok = (func3[1:0] != 2'b00);
  assign src   = func3[2] ? {27'b0, zimm} : rs1_data;

  always_comb begin
    old_val = 32'b0;
    case (csr_addr)
      ADDR_MSTATUS: old_val = mstatus_val;
      ADDR_MIE:     old_val = mie_val;
      ADDR_MTVEC:   old_val = mtvec;
      ADDR_MEPC:    old_val = mepc;
      ADDR_MCAUSE:  old_val = mcause;
      ADDR_MIP:     old_val = mip_val;
      ADDR_MCYCLE:  old_val = mcycle[31:0];
      ADDR_MCYCLEH: old_val = mcycle[63:32];
      default:      old_val = 32'b0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    case (func3[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase
  end

  assign rdata = (csr_reg_rd && op_ok) ? old_val : 32'b0;

  // mret wins over an interrupt; a trap squashes the CSR write of the flushed instruction
  assign irq_pending = mstatus_mie & instr_valid & (|(mip_val & mie_val));
  assign mret_go     = is_mret & instr_valid;
  assign trap_go     = irq_pending & ~is_mret;
  assign wr_en       = csr_reg_wr & op_ok & ~trap_go;

  assign ext_sel    = ext_s2 & mie_meie;
  assign cause_code = ext_sel ? 5'd11 : 5'd7;

  always_comb begin
    epc_taken = 1'b0;
    epc       = 32'b0;
    if (trap_go) begin
      epc_taken = 1'b1;
      epc       = {mtvec[31:2], 2'b00};
      if (mtvec[1:0] == 2'b01)
        epc = {mtvec[31:2], 2'b00} + {25'b0, cause_code, 2'b00};
    end else if (mret_go) begin
      epc_taken = 1'b1;
      epc       = mepc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_s1 <= 1'b0;
      timer_s2 <= 1'b0;
      ext_s1   <= 1'b0;
      ext_s2   <= 1'b0;
    end else begin
      timer_s1 <= timer_irq;
      timer_s2 <= timer_s1;
      ext_s1   <= ext_irq;
      ext_s2   <= ext_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap_go) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_go) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (wr_en && csr_addr == ADDR_MSTATUS) begin
      mstatus_mie  <= new_val[3];
      mstatus_mpie <= new_val[7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_mtie <= 1'b0;
      mie_meie <= 1'b0;
      mtvec    <= 32'b0;
    end else if (wr_en) begin
      if (csr_addr == ADDR_MIE) begin
        mie_mtie <= new_val[7];
        mie_meie <= new_val[11];
      end
      if (csr_addr == ADDR_MTVEC)
        mtvec <= new_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc   <= 32'b0;
      mcause <= 32'b0;
    end else if (trap_go) begin
      mepc   <= {pc_in[31:2], 2'b00};
      mcause <= {1'b1, 26'b0, cause_code};
    end else if (wr_en) begin
      if (csr_addr == ADDR_MEPC)
        mepc <= {new_val[31:2], 2'b00};
      if (csr_addr == ADDR_MCAUSE)
        mcause <= new_val;
    end
  end

  // A write to either half replaces that half and skips this cycle's increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mcycle <= 64'b0;
    else if (wr_en && csr_addr == ADDR_MCYCLE)
      mcycle[31:0] <= new_val;
    else if (wr_en && csr_addr == ADDR_MCYCLEH)
      mcycle[63:32] <= new_val;
    else
      mcycle <= mcycle + 64'd1;
  end

endmodule
